// File: rtl/rect_fill_if.sv
// Command channel and framebuffer write-port bus of rect_fill_engine.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; the
// command fields are sampled only on that edge, and cmd_valid may be held across busy.
interface rect_fill_if #(
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int PIX_W = 1
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_x1;
  logic [15:0]      cmd_y1;
  logic [15:0]      cmd_x2;
  logic [15:0]      cmd_y2;
  logic             cmd_mode;
  logic [PIX_W-1:0] cmd_value;
  logic [XW-1:0]    mem_x;
  logic [YW-1:0]    mem_y;
  logic             mem_re;
  logic             mem_we;
  logic [PIX_W-1:0] mem_rdata;
  logic [PIX_W-1:0] mem_wdata;

  modport master (
    output cmd_valid, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_mode, cmd_value, mem_rdata,
    input  cmd_ready, mem_x, mem_y, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_mode, cmd_value, mem_rdata,
    output cmd_ready, mem_x, mem_y, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill/invert engine on the framebuffer write port; walks the clipped rectangle in raster order.
// Optional FILL_BLANK_GATE_EN: FILL writes and RD reads only issue while blanking=1.
module rect_fill_engine #(
  parameter int FB_W  = 512,
  parameter int FB_H  = 256,
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int PIX_W = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       blanking,
  rect_fill_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {IDLE, SETUP, FILL, RD, WR, DONE} state_t;

  localparam logic [15:0] X_LIM = 16'(FB_W);
  localparam logic [15:0] Y_LIM = 16'(FB_H);
  localparam logic [15:0] X_MAX = 16'(FB_W - 1);
  localparam logic [15:0] Y_MAX = 16'(FB_H - 1);

  state_t           state, state_nxt;
  logic [15:0]      x1_q, y1_q, x2_q, y2_q;
  logic             mode_q;
  logic [PIX_W-1:0] value_q;
  logic [XW-1:0]    x_q, xl_q, xh_q;
  logic [YW-1:0]    y_q, yh_q;
  logic [15:0]      xl, xh, yl, yh, xh_clip, yh_clip;
  logic             empty, go, last, adv;

`ifdef FILL_BLANK_GATE_EN
  assign go = blanking;
`else
  logic unused_blanking;
  assign go              = 1'b1;
  assign unused_blanking = blanking;
`endif

  // Normalise and clip at full 16-bit width; truncation to XW/YW happens at load.
  always_comb begin
    xl      = (x1_q < x2_q) ? x1_q : x2_q;
    xh      = (x1_q < x2_q) ? x2_q : x1_q;
    yl      = (y1_q < y2_q) ? y1_q : y2_q;
    yh      = (y1_q < y2_q) ? y2_q : y1_q;
    empty   = (xl >= X_LIM) || (yl >= Y_LIM);
    xh_clip = (xh > X_MAX) ? X_MAX : xh;
    yh_clip = (yh > Y_MAX) ? Y_MAX : yh;
  end

  assign last      = (x_q == xh_q) && (y_q == yh_q);
  assign adv       = ((state == FILL) && go) || (state == WR);
  assign bus.mem_x = x_q;
  assign bus.mem_y = y_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = reset;
        if (bus.cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        busy = 1'b1;
        if (empty)       state_nxt = DONE;
        else if (mode_q) state_nxt = RD;
        else             state_nxt = FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (go) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = value_q;
          if (last) state_nxt = DONE;
        end
      end
      RD: begin
        busy = 1'b1;
        if (go) begin
          bus.mem_re = 1'b1;
          state_nxt  = WR;
        end
      end
      // WR is never gated: the read data is only valid in this one cycle.
      WR: begin
        busy          = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = ~bus.mem_rdata;
        state_nxt     = last ? DONE : RD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      mode_q  <= 1'b0;
      value_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xl_q    <= '0;
      xh_q    <= '0;
      yh_q    <= '0;
    end else begin
      if ((state == IDLE) && bus.cmd_valid) begin
        x1_q    <= bus.cmd_x1;
        y1_q    <= bus.cmd_y1;
        x2_q    <= bus.cmd_x2;
        y2_q    <= bus.cmd_y2;
        mode_q  <= bus.cmd_mode;
        value_q <= bus.cmd_value;
      end
      if (state == SETUP) begin
        xl_q <= XW'(xl);
        xh_q <= XW'(xh_clip);
        yh_q <= YW'(yh_clip);
        x_q  <= XW'(xl);
        y_q  <= YW'(yl);
      end else if (adv) begin
        if (x_q == xh_q) begin
          x_q <= xl_q;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Testbench for rect_fill_engine: directed test-plan cases plus random rectangles,
// checked against a pixel-list model of the rectangle walk and a framebuffer shadow.
module tb_rect_fill_engine;
  localparam int FB_W  = 512;
  localparam int FB_H  = 256;
  localparam int XW    = 9;
  localparam int YW    = 8;
  localparam int PIX_W = 1;
  localparam int W     = 2 + XW + YW + PIX_W;  // {is_invert, we, x, y, data}
  localparam int LIMIT = 3000;

  logic       clk;
  logic       reset;
  logic       blanking;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  rect_fill_if #(.XW(XW), .YW(YW), .PIX_W(PIX_W)) bus ();

  rect_fill_engine #(.FB_W(FB_W), .FB_H(FB_H), .XW(XW), .YW(YW), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset), .blanking(blanking), .bus(bus),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int n_chk = 0;
  int n_err = 0;
  int wr_seen = 0;
  int bcnt = 0;
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     first_push, last_push;
  logic [PIX_W-1:0] ram    [FB_W*FB_H] = '{default: '0};
  logic [PIX_W-1:0] shadow [FB_W*FB_H] = '{default: '0};

  // ---------------- clock / reset / blanking ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    blanking = 1'b0;
    forever begin
      @(posedge clk); #1;
      bcnt++;
      blanking = bcnt[2];
    end
  end

  // Framebuffer RAM: read data appears one cycle after mem_re.
  always @(posedge clk) begin
    if (bus.mem_we) ram[int'(bus.mem_y) * FB_W + int'(bus.mem_x)] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[int'(bus.mem_y) * FB_W + int'(bus.mem_x)];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_cmd(input int x1, input int y1, input int x2, input int y2,
                           input bit mode, input logic [PIX_W-1:0] val, output int n);
    int xl, xh, yl, yh, a;
    logic [W-1:0] e;
    xl = (x1 < x2) ? x1 : x2;
    xh = (x1 < x2) ? x2 : x1;
    yl = (y1 < y2) ? y1 : y2;
    yh = (y1 < y2) ? y2 : y1;
    n = 0;
    if (xl >= FB_W || yl >= FB_H) return;
    if (xh > FB_W - 1) xh = FB_W - 1;
    if (yh > FB_H - 1) yh = FB_H - 1;
    for (int yy = yl; yy <= yh; yy++) begin
      for (int xx = xl; xx <= xh; xx++) begin
        a = yy * FB_W + xx;
        if (!mode) begin
          e = {1'b0, 1'b1, XW'(xx), YW'(yy), val};
          shadow[a] = val;
        end else begin
          exp_q.push_back({1'b1, 1'b0, XW'(xx), YW'(yy), {PIX_W{1'b0}}});
          if (n == 0) first_push = exp_q[$];
          e = {1'b1, 1'b1, XW'(xx), YW'(yy), ~shadow[a]};
          shadow[a] = ~shadow[a];
        end
        exp_q.push_back(e);
        if (n == 0 && !mode) first_push = e;
        last_push = e;
        n++;
      end
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : cmp_blk
    logic [W-1:0] e;
    if (reset && (bus.mem_re || bus.mem_we)) begin
      check("re_we_exclusive", 32'(bus.mem_re && bus.mem_we), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_access", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("access", 32'({bus.mem_we, bus.mem_x, bus.mem_y, bus.mem_we ? bus.mem_wdata : {PIX_W{1'b0}}}),
              32'(e[W-2:0]));
`ifdef FILL_BLANK_GATE_EN
        if (bus.mem_re || !e[W-1]) check("gated_by_blanking", 32'(blanking), 1);
`endif
      end
      if (bus.mem_we) wr_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input int x1, input int y1, input int x2, input int y2,
                         input bit mode, input logic [PIX_W-1:0] val);
    bus.cmd_x1    = 16'(x1);
    bus.cmd_y1    = 16'(y1);
    bus.cmd_x2    = 16'(x2);
    bus.cmd_y2    = 16'(y2);
    bus.cmd_mode  = mode;
    bus.cmd_value = val;
  endtask

  task automatic wait_done(output int done_t, output int first_t, output bit busy_bad, output bit ready_bad);
    int t;
    t = 0; done_t = 0; first_t = 0; busy_bad = 0; ready_bad = 0;
    while (done_t == 0 && t < LIMIT) begin
      @(negedge clk);
      t++;
      if (first_t == 0 && (bus.mem_re || bus.mem_we)) first_t = t;
      if (bus.cmd_ready) ready_bad = 1;
      if (done) begin
        done_t = t;
        if (busy) busy_bad = 1;
      end else if (!busy) begin
        busy_bad = 1;
      end
    end
    check("done_seen", 32'(done_t != 0), 1);
  endtask

  task automatic run_cmd(input int x1, input int y1, input int x2, input int y2,
                         input bit mode, input logic [PIX_W-1:0] val, input int exp_n);
    int n, done_t, first_t;
    bit busy_bad, ready_bad;
    model_cmd(x1, y1, x2, y2, mode, val, n);
    if (exp_n >= 0) check("model_pixels", n, exp_n);
    @(negedge clk);
    check("ready_before", 32'(bus.cmd_ready), 1);
    set_cmd(x1, y1, x2, y2, mode, val);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    set_cmd(int'($urandom), int'($urandom), int'($urandom), int'($urandom), 1'($urandom), PIX_W'($urandom));
    wait_done(done_t, first_t, busy_bad, ready_bad);
    check("busy_profile", 32'(busy_bad), 0);
    check("ready_while_busy", 32'(ready_bad), 0);
`ifndef FILL_BLANK_GATE_EN
    check("done_cycle", done_t, (n == 0) ? 2 : (mode ? 2 * n + 2 : n + 2));
    if (n > 0) check("first_strobe_cycle", first_t, 2);
`endif
    @(negedge clk);
    check("ready_after_done", 32'(bus.cmd_ready), 1);
    check("done_one_cycle", 32'(done), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, n2, done_t, first_t, base, t, dn;
    int x1, x2, y1, y2, tmp;
    bit busy_bad, ready_bad;

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0, 1'b0, '0);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mem_re", 32'(bus.mem_re), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_x", 32'(bus.mem_x), 0);
    check("rst_mem_y", 32'(bus.mem_y), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.cmd_ready), 1);

    // Basic FILL and corner-order independence
    run_cmd(2, 3, 4, 4, 1'b0, 1'b1, 6);
    check("model_first_px", 32'(first_push), 32'({2'b01, 9'd2, 8'd3, 1'b1}));
    check("model_last_px", 32'(last_push), 32'({2'b01, 9'd4, 8'd4, 1'b1}));
    run_cmd(4, 4, 2, 3, 1'b0, 1'b1, 6);
    check("model_rev_first_px", 32'(first_push), 32'({2'b01, 9'd2, 8'd3, 1'b1}));

    // Clipping, fully-outside rectangle, and 16-bit compare before truncation
    run_cmd(510, 254, 600, 300, 1'b0, 1'b1, 4);
    check("model_clip_last", 32'(last_push), 32'({2'b01, 9'd511, 8'd255, 1'b1}));
    run_cmd(600, 10, 600, 20, 1'b0, 1'b1, 0);
    run_cmd(2, 5, 514, 5, 1'b0, 1'b0, 510);

    // Single-pixel INVERT twice restores the pixel
    run_cmd(7, 7, 7, 7, 1'b1, 1'b0, 1);
    check("model_inv_read", 32'(first_push), 32'({2'b10, 9'd7, 8'd7, 1'b0}));
    check("model_inv_write", 32'(last_push), 32'({2'b11, 9'd7, 8'd7, 1'b1}));
    check("ram_inv_once", 32'(ram[7 * FB_W + 7]), 1);
    run_cmd(7, 7, 7, 7, 1'b1, 1'b0, 1);
    check("ram_inv_twice", 32'(ram[7 * FB_W + 7]), 0);

    // cmd_valid held high: second command taken only after done
    model_cmd(20, 20, 22, 20, 1'b0, 1'b1, n);
    model_cmd(21, 20, 20, 20, 1'b1, 1'b0, n2);
    @(negedge clk);
    set_cmd(20, 20, 22, 20, 1'b0, 1'b1);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    set_cmd(21, 20, 20, 20, 1'b1, 1'b0);
    wait_done(done_t, first_t, busy_bad, ready_bad);
    check("hold_ready_while_busy", 32'(ready_bad), 0);
`ifndef FILL_BLANK_GATE_EN
    check("hold_first_done", done_t, n + 2);
`endif
    @(negedge clk);
    check("hold_ready_next", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_done(done_t, first_t, busy_bad, ready_bad);
`ifndef FILL_BLANK_GATE_EN
    check("hold_second_done", done_t, 2 * n2 + 2);
`endif
    @(negedge clk);
    check("hold_queue_drained", exp_q.size(), 0);

    // Reset during the 3rd write of a 12-pixel FILL
    model_cmd(100, 100, 105, 101, 1'b0, 1'b1, n);
    base = wr_seen;
    @(negedge clk);
    set_cmd(100, 100, 105, 101, 1'b0, 1'b1);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    t = 0;
    while (wr_seen < base + 3 && t < LIMIT) begin
      @(negedge clk); #1;
      t++;
    end
    check("rst_at_third_write", wr_seen - base, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.mem_we), 0);
    check("mid_rst_re", 32'(bus.mem_re), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 0);
    exp_q.delete();
    for (int k = 2; k < 12; k++) shadow[(100 + k / 6) * FB_W + 100 + k % 6] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    base = wr_seen;
    dn = 0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.cmd_ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("post_rst_no_done", dn, 0);
    check("post_rst_no_writes", wr_seen - base, 0);
    check("rst_px2_written", 32'(ram[100 * FB_W + 101]), 1);
    check("rst_px3_not_written", 32'(ram[100 * FB_W + 102]), 0);

    // Random rectangles, some clipped or empty, mixed modes
    for (int i = 0; i < 25; i++) begin
      x1 = $urandom_range(0, 520);
      y1 = $urandom_range(0, 262);
      x2 = x1 + $urandom_range(0, 10);
      y2 = y1 + $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) begin tmp = x1; x1 = x2; x2 = tmp; end
      if ($urandom_range(0, 1) == 1) begin tmp = y1; y1 = y2; y2 = tmp; end
      run_cmd(x1, y1, x2, y2, 1'($urandom_range(0, 1)), PIX_W'($urandom_range(0, 1)), -1);
    end

    dn = 0;
    for (int a = 0; a < FB_W * FB_H; a++) if (ram[a] !== shadow[a]) dn++;
    check("ram_image", dn, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Parametrised rectangle-fill engine that drives the write side of the GPU framebuffer RAM (the port the VGA scan-out does not use). Accepts one rectangle command per handshake, normalises and clips its corners to the framebuffer, then walks the rectangle in raster order. Each pixel is written with a constant value (FILL) or bitwise-inverted in place (INVERT, read-modify-write). Generalises the earlier single-bit, fill-only command latch with parametric geometry, pixel depth, a second mode, busy/done status and optional blanking gating.

## Interface
- FB_W, default 512: framebuffer width in pixels.
- FB_H, default 256: framebuffer height in pixels.
- XW, default 9: x address width; must satisfy 2^XW >= FB_W.
- YW, default 8: y address width; must satisfy 2^YW >= FB_H.
- PIX_W, default 1: bits per pixel.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; clk is the only clock.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine idle and can accept a command.
- cmd_x1, cmd_y1, cmd_x2, cmd_y2  input  16 each  unsigned corner coordinates, inclusive; any order.
- cmd_mode  input  1  0 = FILL, 1 = INVERT.
- cmd_value  input  PIX_W  fill value; ignored in INVERT.
- blanking  input  1  display blanking flag from the VGA timing block.
- mem_x  output  XW  pixel x address.
- mem_y  output  YW  pixel y address.
- mem_re  output  1  read strobe; RAM returns mem_rdata exactly 1 cycle later.
- mem_rdata  input  PIX_W  read data.
- mem_we  output  1  write strobe.
- mem_wdata  output  PIX_W  write data.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle pulse on completion.

## Operation
- States: IDLE, SETUP, FILL, RD, WR, DONE.
- IDLE: cmd_ready=1. Accept on cmd_valid & cmd_ready. Latch the operands; go to SETUP. cmd_valid while not IDLE is ignored (cmd_ready=0).
- SETUP (1 cycle):
  - Normalise: xl=min(x1,x2), xh=max(x1,x2); same for y.
  - Clip: empty if xl>=FB_W or yl>=FB_H. Otherwise xh=min(xh,FB_W-1) and yh=min(yh,FB_H-1).
  - Compare at 16 bits; truncate to XW/YW only after clipping.
  - Empty goes to DONE. Otherwise load x=xl, y=yl, then go to FILL (mode 0) or RD (mode 1).
- FILL: mem_we=1, mem_wdata=cmd_value at (x,y) each cycle.
- RD: mem_re=1 at (x,y); next state WR.
- WR: mem_we=1, mem_wdata=~mem_rdata at the same (x,y); next state RD, or DONE after the last pixel.
- Raster advance after each write:
  - x==xh: x=xl and y=y+1.
  - Otherwise x=x+1.
  - Write at (xh,yh) is the last pixel; next state DONE.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- Single-pixel rectangle (x1==x2, y1==y2): exactly one write.

## Timing
- Reset values: cmd_ready=0 while reset is asserted, then 1 (IDLE). busy, done, mem_re, mem_we = 0. mem_x, mem_y, mem_wdata = 0.
- Accept at edge 0 → SETUP in cycle 1 → first strobe in cycle 2.
- FILL with N clipped pixels: mem_we high for N consecutive cycles (2..N+1); done in cycle N+2; cmd_ready=1 in cycle N+3.
- INVERT: 2 cycles per pixel; done in cycle 2N+2.
- Empty rectangle: done in cycle 2; no strobes.
- busy is high in cycles 1 through the last strobe cycle.
- mem_re and mem_we are never high in the same cycle.
- Reset asserted mid-operation: strobes drop immediately (asynchronous); the command is discarded; no done pulse.

## Configuration
- FILL_BLANK_GATE_EN defined:
  - FILL writes and RD reads issue only in cycles where blanking=1.
  - When blanking=0, the state, mem_x and mem_y hold and strobes stay low.
  - A WR always completes the cycle after its RD, even if blanking has dropped.
  - SETUP and DONE are not gated.
- FILL_BLANK_GATE_EN undefined: blanking is ignored; timing is exactly as in Timing.

## Test plan
- FILL (2,3)-(4,4), value 1 → 6 writes in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) in cycles 2-7; done in cycle 8.
- Corners reversed (4,4)-(2,3) → identical write sequence to the previous test.
- Clip, FB 512x256: (510,254)-(600,300) → writes (510,254),(511,254),(510,255),(511,255) only. Separately, x1=x2=600 → done in cycle 2, no writes.
- INVERT 1 px at (7,7), RAM holds 0 → mem_re in cycle 2, mem_we with wdata=1 in cycle 3, done in cycle 4; a second INVERT restores 0.
- cmd_valid held high during an operation → the second command is accepted only in the cycle after done. Reset at the 3rd write → no further writes, no done; busy=0, cmd_ready=1 after release.
- With FILL_BLANK_GATE_EN, blanking toggled 4 cycles on / 4 off → writes occur only in blanking cycles; total write count is unchanged.
